// File: rtl/mandel_iter.sv
// Escape-time engine: iterates z <- z^2 + c, one step per clock, and reports the iteration count.
// Optional build macro PIXEL_TAG_EN adds in_tag/out_tag pixel tag passthrough.
module mandel_iter #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 21,
  parameter int MAX_ITER  = 255,
  parameter int TAG_W     = 20,
  localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] c_re,
  input  logic [DATA_W-1:0] c_im,
`ifdef PIXEL_TAG_EN
  input  logic [TAG_W-1:0]  in_tag,
  output logic [TAG_W-1:0]  out_tag,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped
);

  // state | meaning
  // IDLE  | waiting for a point, in_ready=1
  // ITER  | one z update (or escape/cap decision) per clock
  // DONE  | result held; out_valid rises one cycle after entry, leaves on out_ready
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW:0] MAG_LIM = (PW + 1)'(4) << (2 * FRAC_BITS);
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

  state_t state, state_nx;

  logic signed [DATA_W-1:0] c_re_q, c_im_q, z_re, z_im;
  logic        [ITER_W-1:0] count;

  logic signed [PW-1:0] p_rr, p_ii, p_ri;
  logic signed [PW:0]   mag, diff;
  logic signed [DATA_W-1:0] z_re_nx, z_im_nx;
  logic esc, at_cap;

  always_comb begin
    p_rr    = z_re * z_re;
    p_ii    = z_im * z_im;
    p_ri    = z_re * z_im;
    mag     = (PW + 1)'(p_rr) + (PW + 1)'(p_ii);
    diff    = (PW + 1)'(p_rr) - (PW + 1)'(p_ii);
    // Truncation to DATA_W wraps deliberately; the escape test uses the full-width mag.
    z_re_nx = DATA_W'(diff >>> FRAC_BITS) + c_re_q;
    z_im_nx = DATA_W'(p_ri >>> (FRAC_BITS - 1)) + c_im_q;
    esc     = (mag > MAG_LIM);
    at_cap  = (count == ITER_CAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = ITER;
      ITER: if (esc || at_cap) state_nx = DONE;
      DONE: if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_re_q     <= '0;
      c_im_q     <= '0;
      z_re       <= '0;
      z_im       <= '0;
      count      <= '0;
      iter_count <= '0;
      escaped    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_re_q <= c_re;
            c_im_q <= c_im;
            z_re   <= '0;
            z_im   <= '0;
            count  <= '0;
          end
        end
        ITER: begin
          if (esc) begin
            iter_count <= count;
            escaped    <= 1'b1;
          end else if (at_cap) begin
            iter_count <= ITER_CAP;
            escaped    <= 1'b0;
          end else begin
            z_re  <= z_re_nx;
            z_im  <= z_im_nx;
            count <= count + ITER_W'(1);
          end
        end
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

`ifdef PIXEL_TAG_EN
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           tag_q <= '0;
    else if (!flush && in_ready && in_valid) tag_q <= in_tag;
  end

  assign out_tag = tag_q;
`else
  wire unused_tag_w = (TAG_W != 0);
`endif

endmodule

// File: tb/tb_mandel_iter.sv
// Scoreboard bench for mandel_iter: spec points, random points against a reference model,
// backpressure, flush and mid-run reset.
module tb_mandel_iter;
  localparam int MAXI = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] c_re = '0;
  logic [31:0] c_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  iter_count;
  logic        escaped;

  mandel_iter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .c_re(c_re), .c_im(c_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .iter_count(iter_count), .escaped(escaped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int iter;
    int esc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: 64-bit squares, 65-bit magnitude, wrap to 32 bits after the shift.
  function automatic void model(input logic signed [31:0] cr, input logic signed [31:0] ci,
                                output int it, output int esc);
    logic signed [31:0] zr, zi;
    longint sr, si, sx, t;
    logic signed [64:0] m;
    zr = '0; zi = '0; it = MAXI; esc = 0;
    for (int k = 0; k <= MAXI; k++) begin
      sr = longint'(zr) * longint'(zr);
      si = longint'(zi) * longint'(zi);
      sx = longint'(zr) * longint'(zi);
      m  = 65'(sr) + 65'(si);
      if (m > 65'sd17592186044416) begin
        it = k; esc = 1; return;
      end
      if (k == MAXI) begin
        it = MAXI; esc = 0; return;
      end
      t  = (sr - si) >>> 21;
      zr = t[31:0] + cr;
      t  = sx >>> 20;
      zi = t[31:0] + ci;
    end
  endfunction

  // Drive one point, wait for its result; leaves the DUT in DONE with out_valid=1.
  task automatic send_wait(input logic [31:0] cr, input logic [31:0] ci,
                           input int ei, input int ee, input string tag);
    exp_t e;
    exp_t got;
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; c_re = cr; c_im = ci;
    e.iter = ei; e.esc = ee; e.lat = ei + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_iter"}, iter_count, got.iter);
    check({tag, "_esc"}, escaped, got.esc);
    check({tag, "_lat"}, lat, got.lat);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rdy_after"}, in_ready, 1);
    check({tag, "_vld_after"}, out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ei, ee, seen;
    logic [31:0] rr, ri;
    logic [7:0] hold_it;
    logic hold_esc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_iter", iter_count, 0);
    check("rst_esc", escaped, 0);
    rst_n = 1'b1;

    send_wait(32'h0000_0000, 32'h0000_0000, 255, 0, "c00");  drain("c00");
    send_wait(32'h0020_0000, 32'h0000_0000, 3, 1, "c10");    drain("c10");
    send_wait(32'hFFC0_0000, 32'h0000_0000, 255, 0, "cm20"); drain("cm20");
    send_wait(32'h0040_0000, 32'h0040_0000, 1, 1, "c22");    drain("c22");

    for (int n = 0; n < 8; n++) begin
      rr = 32'($urandom_range(0, 32'h0070_0000)) - 32'h0050_0000;
      ri = 32'($urandom_range(0, 32'h0050_0000)) - 32'h0028_0000;
      model(rr, ri, ei, ee);
      send_wait(rr, ri, ei, ee, $sformatf("rnd%0d", n));
      drain($sformatf("rnd%0d", n));
    end

    // Backpressure: result held, new input ignored.
    out_ready = 1'b0;
    send_wait(32'h0040_0000, 32'h0040_0000, 1, 1, "bp");
    hold_it = iter_count; hold_esc = escaped;
    in_valid = 1'b1; c_re = 32'h0; c_im = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_iter", iter_count, hold_it);
      check("bp_esc", escaped, hold_esc);
    end
    in_valid = 1'b0;
    drain("bp");
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid || !in_ready) seen = 1; end
    check("bp_no_accept", seen, 0);

    // Flush four cycles into an ITER run.
    @(posedge clk); #1;
    in_valid = 1'b1; c_re = 32'h0; c_im = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_in_ready", in_ready, 1);
    check("fl_out_valid", out_valid, 0);
    seen = 0;
    repeat (300) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    check("fl_no_stale", seen, 0);

    // Flush drops a held result, beating out_ready.
    out_ready = 1'b0;
    send_wait(32'h0020_0000, 32'h0000_0000, 3, 1, "fld");
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fld_out_valid", out_valid, 0);
    check("fld_in_ready", in_ready, 1);

    // Reset mid-ITER.
    @(posedge clk); #1;
    in_valid = 1'b1; c_re = 32'h0; c_im = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rs_in_ready", in_ready, 1);
    check("rs_out_valid", out_valid, 0);
    check("rs_iter", iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (300) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    check("rs_no_stale", seen, 0);

    send_wait(32'h0020_0000, 32'h0000_0000, 3, 1, "post"); drain("post");
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
